// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier.
// Digit codes are packed as {neg, dbl, zero}.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam logic [2:0] ZERO = 3'b001;
  localparam logic [2:0] P1   = 3'b000;
  localparam logic [2:0] P2   = 3'b010;
  localparam logic [2:0] M1   = 3'b100;
  localparam logic [2:0] M2   = 3'b110;

  function automatic int iter_of(input int w);
    return w / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_recode.sv
// Radix-4 Booth recoder: 3-bit window {b1,b0,b-1} to a signed digit.
// Outputs: neg (subtract), dbl (use 2A), zero (add nothing).
module booth_r4_recode
  import booth_pkg::*;
(
  input  logic [2:0] win,
  output logic       neg,
  output logic       dbl,
  output logic       zero
);

  logic [2:0] dig;

  // window to digit code
  always_comb begin
    dig = ZERO;
    unique case (win)
      3'b001, 3'b010: dig = P1;
      3'b011:         dig = P2;
      3'b100:         dig = M2;
      3'b101, 3'b110: dig = M1;
      default:        dig = ZERO;
    endcase
  end

  assign {neg, dbl, zero} = dig;

endmodule

// File: rtl/booth_r4_mult.sv
// Sequential radix-4 Booth multiplier, 2 multiplier bits per clock.
// Optional BOOTH_ZERO_BYPASS_EN: zero operand skips straight to DONE.
module booth_r4_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int ITER = iter_of(WIDTH);
  localparam int AW   = WIDTH + 3;
  localparam int MW   = WIDTH + 2;
  localparam int FW   = AW + MW + 1;
  localparam int CW   = $clog2(ITER + 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic             is_signed_q;
  logic [AW-1:0]    acc;
  logic [MW-1:0]    mq;
  logic             g;
  logic [CW-1:0]    cnt;

  logic             neg;
  logic             dbl;
  logic             zero;
  logic [AW-1:0]    a_ext;
  logic [AW-1:0]    mag;
  logic [AW-1:0]    addend;
  logic [AW-1:0]    sum;
  logic [FW-1:0]    nxt;
  logic [MW-1:0]    b_ext;

  booth_r4_recode u_rec (
    .win  ({mq[1:0], g}),
    .neg  (neg),
    .dbl  (dbl),
    .zero (zero)
  );

  // one Booth step: add digit*A, then arithmetic shift by 2
  always_comb begin
    a_ext  = {{3{is_signed_q & a_q[WIDTH-1]}}, a_q};
    mag    = dbl ? (a_ext << 1) : a_ext;
    addend = zero ? '0 : (neg ? -mag : mag);
    sum    = acc + addend;
    nxt    = $signed({sum, mq, g}) >>> 2;
    b_ext  = {{2{is_signed & multiplier[WIDTH-1]}}, multiplier};
  end

  // FSM, datapath registers and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      product     <= '0;
      a_q         <= '0;
      is_signed_q <= 1'b0;
      acc         <= '0;
      mq          <= '0;
      g           <= 1'b0;
      cnt         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q         <= multiplicand;
            is_signed_q <= is_signed;
            acc         <= '0;
            mq          <= b_ext;
            g           <= 1'b0;
            cnt         <= CW'(ITER);
            in_ready    <= 1'b0;
            busy        <= 1'b1;
`ifdef BOOTH_ZERO_BYPASS_EN
            if (multiplicand == '0 || multiplier == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              product   <= '0;
            end else begin
              state <= CALC;
            end
`else
            state <= CALC;
`endif
          end
        end
        CALC: begin
          {acc, mq, g} <= nxt;
          cnt          <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            product   <= nxt[2*WIDTH:1];
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_mult.sv
// Self-checking bench for booth_r4_mult (WIDTH=8 and WIDTH=16).
// Reference products come from plain integer multiplication.
module tb_booth_r4_mult;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_iv = 1'b0;
  logic        a_ir;
  logic [7:0]  a_mc = '0;
  logic [7:0]  a_mp = '0;
  logic        a_sg = 1'b0;
  logic        a_ov;
  logic        a_or = 1'b0;
  logic [15:0] a_pr;
  logic        a_bz;

  logic        b_iv = 1'b0;
  logic        b_ir;
  logic [15:0] b_mc = '0;
  logic [15:0] b_mp = '0;
  logic        b_sg = 1'b0;
  logic        b_ov;
  logic        b_or = 1'b0;
  logic [31:0] b_pr;
  logic        b_bz;

  booth_r4_mult #(.WIDTH(8)) u8 (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (a_iv),
    .in_ready     (a_ir),
    .multiplicand (a_mc),
    .multiplier   (a_mp),
    .is_signed    (a_sg),
    .out_valid    (a_ov),
    .out_ready    (a_or),
    .product      (a_pr),
    .busy         (a_bz)
  );

  booth_r4_mult #(.WIDTH(16)) u16 (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (b_iv),
    .in_ready     (b_ir),
    .multiplicand (b_mc),
    .multiplier   (b_mp),
    .is_signed    (b_sg),
    .out_valid    (b_ov),
    .out_ready    (b_or),
    .product      (b_pr),
    .busy         (b_bz)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input int w,
                                          input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic s);
    longint x;
    longint y;
    longint p;
    x = longint'(a);
    y = longint'(b);
    if (s) begin
      x = (x <<< (64 - w)) >>> (64 - w);
      y = (y <<< (64 - w)) >>> (64 - w);
    end
    p = x * y;
    return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  // issue one op on the 8-bit unit, wait for out_valid (not taken)
  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic s,
                      output logic [15:0] p, output int lat);
    @(negedge clk);
    chk("r8_in_ready", 64'(a_ir), 64'd1);
    a_mc = a;
    a_mp = b;
    a_sg = s;
    a_iv = 1'b1;
    @(posedge clk);
    lat = 1;
    #1;
    a_iv = 1'b0;
    a_mc = 8'hA5;
    a_mp = 8'h5A;
    while (!a_ov && lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
    end
    if (!a_ov) chk("r8_timeout", 64'd0, 64'd1);
    p = a_pr;
  endtask

  task automatic take8();
    a_or = 1'b1;
    @(posedge clk);
    #1;
    a_or = 1'b0;
    chk("r8_ov_clr", 64'(a_ov), 64'd0);
    chk("r8_ir_back", 64'(a_ir), 64'd1);
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b,
                       input logic s);
    int lat;
    int exp_lat;
    @(negedge clk);
    chk("r16_in_ready", 64'(b_ir), 64'd1);
    b_mc = a;
    b_mp = b;
    b_sg = s;
    b_iv = 1'b1;
    @(posedge clk);
    lat = 1;
    #1;
    b_iv = 1'b0;
    b_mc = 16'($urandom);
    b_mp = 16'($urandom);
    while (!b_ov && lat < 60) begin
      @(posedge clk);
      lat++;
      #1;
    end
    if (!b_ov) chk("r16_timeout", 64'd0, 64'd1);
    exp_lat = 10;
`ifdef BOOTH_ZERO_BYPASS_EN
    if (a == 16'd0 || b == 16'd0) exp_lat = 1;
`endif
    chk("r16_lat", 64'(lat), 64'(exp_lat));
    chk(s ? "r16_sprod" : "r16_uprod", 64'(b_pr),
        ref_mul(16, 32'(a), 32'(b), s));
    b_or = 1'b1;
    @(posedge clk);
    #1;
    b_or = 1'b0;
  endtask

  initial begin
    logic [15:0] p;
    int lat;
    int zlat;

    zlat = 6;
`ifdef BOOTH_ZERO_BYPASS_EN
    zlat = 1;
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(a_ir), 64'd1);
    chk("rst_out_valid", 64'(a_ov), 64'd0);
    chk("rst_busy", 64'(a_bz), 64'd0);
    chk("rst_product", 64'(a_pr), 64'd0);
    rst = 1'b0;

    run8(8'h80, 8'h80, 1'b1, p, lat);
    chk("s_m128sq", 64'(p), 64'h4000);
    chk("s_m128sq_lat", 64'(lat), 64'd6);
    chk("busy_done", 64'(a_bz), 64'd1);
    take8();

    run8(8'hFF, 8'h7F, 1'b1, p, lat);
    chk("s_m1x127", 64'(p), 64'hFF81);
    take8();

    run8(8'hFF, 8'hFF, 1'b0, p, lat);
    chk("u_255sq", 64'(p), 64'hFE01);
    take8();

    run8(8'd0, 8'hC3, 1'b1, p, lat);
    chk("zero_prod", 64'(p), 64'd0);
    chk("zero_lat", 64'(lat), 64'(zlat));
    take8();

    // backpressure
    run8(8'd200, 8'd3, 1'b0, p, lat);
    chk("u_200x3", 64'(p), 64'h0258);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_prod", 64'(a_pr), 64'h0258);
      chk("bp_ov", 64'(a_ov), 64'd1);
      chk("bp_ir", 64'(a_ir), 64'd0);
    end
    take8();

    // in_valid during CALC must be ignored
    @(negedge clk);
    a_mc = 8'd3;
    a_mp = 8'hF9;
    a_sg = 1'b1;
    a_iv = 1'b1;
    @(posedge clk);
    #1;
    a_iv = 1'b0;
    @(posedge clk);
    #1;
    a_mc = 8'd5;
    a_mp = 8'd5;
    a_sg = 1'b0;
    a_iv = 1'b1;
    chk("busy_ir", 64'(a_ir), 64'd0);
    chk("busy_bz", 64'(a_bz), 64'd1);
    @(posedge clk);
    #1;
    a_iv = 1'b0;
    lat = 0;
    while (!a_ov && lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
    end
    chk("busy_prod", 64'(a_pr), 64'hFFEB);
    take8();
    repeat (8) @(posedge clk);
    #1;
    chk("busy_no_ghost", 64'(a_ov), 64'd0);

    // reset in the 3rd CALC cycle
    @(negedge clk);
    a_mc = 8'd100;
    a_mp = 8'd50;
    a_sg = 1'b0;
    a_iv = 1'b1;
    @(posedge clk);
    #1;
    a_iv = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_ov", 64'(a_ov), 64'd0);
    chk("abort_ir", 64'(a_ir), 64'd1);
    chk("abort_prod", 64'(a_pr), 64'd0);
    run8(8'd7, 8'd6, 1'b0, p, lat);
    chk("after_rst_7x6", 64'(p), 64'd42);
    chk("after_rst_lat", 64'(lat), 64'd6);
    take8();

    // WIDTH=16 random against the reference
    run16(16'h8000, 16'h8000, 1'b1);
    run16(16'hFFFF, 16'hFFFF, 1'b0);
    run16(16'h0000, 16'h1234, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 97 == 0) ra = '0;
      if (i % 89 == 0) rb = '0;
      run16(ra, rb, i < 1000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
